// File: rtl/cmac_bp_generator.sv
// AXI-stream sink that discards CMAC RX data and drives tready with
// alternating accept/stall windows; counts beats, packets and stalls.
module cmac_bp_generator #(
    parameter int DW    = 512,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cfg_gap_cycles,
    input  logic [CNT_W-1:0] cfg_bp_cycles,
    input  logic [CNT_W-1:0] cfg_burst_count,
    input  logic [DW-1:0]    axis_tdata,
    input  logic             axis_tlast,
    input  logic             axis_tvalid,
    output logic             axis_tready,
    output logic             busy,
    output logic [CNT_W-1:0] bp_events,
    output logic [63:0]      beats_rcvd,
    output logic [31:0]      packets_rcvd
);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        BP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] bp_q, bp_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0] bp_events_q, bp_events_d;
    logic [63:0]      beats_q, beats_d;
    logic [31:0]      pkts_q, pkts_d;
    logic             tready_q, tready_d;
    logic             accept;
    logic [CNT_W-1:0] ev_next;
    logic             unused_tdata;

    assign unused_tdata = ^axis_tdata;

    function automatic logic [CNT_W-1:0] max1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign accept  = axis_tvalid & tready_q;
    assign ev_next = bp_events_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        bp_d        = bp_q;
        burst_d     = burst_q;
        bp_events_d = bp_events_q;
        beats_d     = beats_q + 64'(accept);
        pkts_d      = pkts_q + 32'(accept & axis_tlast);

        unique case (state_q)
            IDLE: begin
                if (start && !stop && cfg_bp_cycles != '0) begin
                    gap_d       = max1(cfg_gap_cycles);
                    bp_d        = cfg_bp_cycles;
                    burst_d     = cfg_burst_count;
                    cnt_d       = max1(cfg_gap_cycles);
                    bp_events_d = '0;
                    beats_d     = '0;
                    pkts_d      = '0;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = bp_q;
                    state_d = BP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    bp_events_d = ev_next;
                    if (burst_q != '0 && ev_next == burst_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = gap_q;
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // abort wins over everything, including a same-cycle start
        if (stop) begin
            state_d = IDLE;
        end

        tready_d = (state_d != BP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            bp_q        <= '0;
            burst_q     <= '0;
            bp_events_q <= '0;
            beats_q     <= '0;
            pkts_q      <= '0;
            tready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            bp_q        <= bp_d;
            burst_q     <= burst_d;
            bp_events_q <= bp_events_d;
            beats_q     <= beats_d;
            pkts_q      <= pkts_d;
            tready_q    <= tready_d;
        end
    end

    assign axis_tready  = tready_q;
    assign busy         = (state_q != IDLE);
    assign bp_events    = bp_events_q;
    assign beats_rcvd   = beats_q;
    assign packets_rcvd = pkts_q;

endmodule

// File: tb/tb_cmac_bp_generator.sv
// Directed bench for cmac_bp_generator: tready window patterns,
// stop/start corner cases, beat/packet counting and mid-run reset.
module tb_cmac_bp_generator;

    localparam int DW    = 512;
    localparam int CNT_W = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] cfg_gap_cycles;
    logic [CNT_W-1:0] cfg_bp_cycles;
    logic [CNT_W-1:0] cfg_burst_count;
    logic [DW-1:0]    axis_tdata;
    logic             axis_tlast;
    logic             axis_tvalid;
    logic             axis_tready;
    logic             busy;
    logic [CNT_W-1:0] bp_events;
    logic [63:0]      beats_rcvd;
    logic [31:0]      packets_rcvd;

    int n_assert;
    int n_fail;

    cmac_bp_generator #(
        .DW   (DW),
        .CNT_W(CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .cfg_gap_cycles (cfg_gap_cycles),
        .cfg_bp_cycles  (cfg_bp_cycles),
        .cfg_burst_count(cfg_burst_count),
        .axis_tdata     (axis_tdata),
        .axis_tlast     (axis_tlast),
        .axis_tvalid    (axis_tvalid),
        .axis_tready    (axis_tready),
        .busy           (busy),
        .bp_events      (bp_events),
        .beats_rcvd     (beats_rcvd),
        .packets_rcvd   (packets_rcvd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int idx;
        int cycles;
        logic acc;

        n_assert        = 0;
        n_fail          = 0;
        reset           = 1'b1;
        start           = 1'b0;
        stop            = 1'b0;
        cfg_gap_cycles  = '0;
        cfg_bp_cycles   = '0;
        cfg_burst_count = '0;
        axis_tdata      = '0;
        axis_tlast      = 1'b0;
        axis_tvalid     = 1'b0;

        // 1: reset, then idle accepts everything
        repeat (4) @(negedge clk);
        check("rst_tready", 64'(axis_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_beats", beats_rcvd, 64'd0);
        check("rst_pkts", 64'(packets_rcvd), 64'd0);
        check("rst_events", 64'(bp_events), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("t1_tready", 64'(axis_tready), 64'd1);
        axis_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            axis_tdata = {16{$urandom}};
            @(negedge clk);
        end
        axis_tvalid = 1'b0;
        check("t1_beats", beats_rcvd, 64'd10);
        check("t1_busy", 64'(busy), 64'd0);

        // 2: gap=3 bp=5 burst=2; later cfg changes must be ignored
        cfg_gap_cycles  = 3;
        cfg_bp_cycles   = 5;
        cfg_burst_count = 2;
        start           = 1'b1;
        @(negedge clk);
        start           = 1'b0;
        cfg_gap_cycles  = 7;
        cfg_bp_cycles   = 1;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("t2_tready[%0d]", i), 64'(axis_tready),
                  64'(!((i >= 3 && i < 8) || (i >= 11 && i < 16))));
            check($sformatf("t2_busy[%0d]", i), 64'(busy),
                  64'(i < 16));
            @(negedge clk);
        end
        check("t2_events", 64'(bp_events), 64'd2);
        check("t2_beats_clr", beats_rcvd, 64'd0);

        // 3: gap=0 -> 1, bp=2, endless until stop
        cfg_gap_cycles  = 0;
        cfg_bp_cycles   = 2;
        cfg_burst_count = 0;
        start           = 1'b1;
        @(negedge clk);
        start           = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("t3_tready[%0d]", i), 64'(axis_tready),
                  64'(i % 3 == 0));
            if (i == 19) begin
                check("t3_events_at_stop", 64'(bp_events), 64'd6);
                stop = 1'b1;
            end
            @(negedge clk);
        end
        stop = 1'b0;
        check("t3_tready_stop", 64'(axis_tready), 64'd1);
        check("t3_busy_stop", 64'(busy), 64'd0);
        check("t3_events_hold", 64'(bp_events), 64'd6);

        // 4: bp=0 start ignored; start+stop together ignored
        axis_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        axis_tvalid = 1'b0;
        check("t4_beats_idle", beats_rcvd, 64'd3);
        cfg_gap_cycles = 2;
        cfg_bp_cycles  = 0;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_bp0_busy", 64'(busy), 64'd0);
        check("t4_bp0_tready", 64'(axis_tready), 64'd1);
        check("t4_bp0_events", 64'(bp_events), 64'd6);
        check("t4_bp0_beats", beats_rcvd, 64'd3);
        cfg_bp_cycles = 4;
        start         = 1'b1;
        stop          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("t4_ss_busy", 64'(busy), 64'd0);
        check("t4_ss_events", 64'(bp_events), 64'd6);
        check("t4_ss_beats", beats_rcvd, 64'd3);
        @(negedge clk);
        check("t4_ss_busy2", 64'(busy), 64'd0);

        // 5: 3 packets x 4 beats under gap=2 bp=3
        cfg_gap_cycles  = 2;
        cfg_bp_cycles   = 3;
        cfg_burst_count = 0;
        start           = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        idx    = 0;
        cycles = 0;
        while (idx < 12 && cycles < 100) begin
            axis_tvalid = 1'b1;
            axis_tlast  = (idx % 4 == 3);
            axis_tdata  = {16{$urandom}};
            acc         = axis_tready;
            @(negedge clk);
            cycles++;
            if (acc) idx++;
        end
        axis_tvalid = 1'b0;
        axis_tlast  = 1'b0;
        check("t5_cycles", 64'(cycles), 64'd27);
        check("t5_beats", beats_rcvd, 64'd12);
        check("t5_pkts", 64'(packets_rcvd), 64'd3);
        check("t5_events", 64'(bp_events), 64'd5);
        cfg_bp_cycles = 9;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_busy_start_ign", 64'(busy), 64'd1);
        check("t5_events_no_clr", 64'(bp_events), 64'd5);
        check("t5_beats_no_clr", beats_rcvd, 64'd12);
        check("t5_tready_bp", 64'(axis_tready), 64'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t5_busy_stop", 64'(busy), 64'd0);

        // 6: reset in the middle of a long stall window
        cfg_gap_cycles = 1;
        cfg_bp_cycles  = 100;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_tready_bp", 64'(axis_tready), 64'd0);
        check("t6_busy_bp", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_tready", 64'(axis_tready), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_events", 64'(bp_events), 64'd0);
        check("t6_rst_beats", beats_rcvd, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("t6_rel_tready", 64'(axis_tready), 64'd1);
        check("t6_rel_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
